text_normalizer: RTL and testbench
==================================

// Module: text_normalizer
// PURPOSE
//   Upstream stage of the block checker: accepts raw ASCII bytes over a valid/ready
//   handshake, normalizes whitespace, drops control characters and buffers results
//   in a small FIFO. Emits one cleaned character per accepted out beat; the checker
//   advances only on out_valid && out_ready.
// PARAMETERS
//   DEPTH   8   FIFO entries; power of two, >= 2
//   ADDR_W  3   log2(DEPTH)
//   CNT_W   16  width of drop_cnt
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low (0 = reset)
//   in_valid   in   1      in_data is valid this cycle
//   in_data    in   8      raw ASCII byte
//   in_ready   out  1      byte accepted when in_valid && in_ready
//   out_valid  out  1      out_data holds a normalized character
//   out_data   out  8      FIFO head (first-word-fall-through)
//   out_ready  in   1      consumer takes out_data when out_valid && out_ready
//   drop_cnt   out  CNT_W  accepted bytes not written to FIFO (saturating)
// BEHAVIOUR
//   Reset: FIFO empty, wr/rd ptr=0, prev_space=1, drop_cnt=0; out_valid=0, out_data=0,
//     in_ready=1. Reset takes effect immediately mid-stream; buffered data is discarded.
//   Handshake: in_ready = !full (combinational from registered count); no push when full,
//     even if a pop occurs in the same cycle. out_valid = !empty.
//   Classification of an accepted byte b:
//     SPACE: b in {0x20, 0x09, 0x0A, 0x0D} -> 0x20
//     CTRL : b < 0x20 (not SPACE) or b >= 0x7F -> dropped
//     CHAR : otherwise -> b unchanged (no case folding)
//   Collapse: SPACE with prev_space=1 -> dropped; SPACE with prev_space=0 -> push 0x20,
//     prev_space<=1. CHAR -> push b, prev_space<=0. CTRL -> dropped, prev_space unchanged.
//     Because prev_space resets to 1, leading whitespace is dropped.
//   drop_cnt: +1 per dropped byte; holds at 2^CNT_W-1. Not cleared by FIFO drain.
//   FIFO: DEPTH entries, count register 0..DEPTH (ADDR_W+1 bits). Pointers wrap modulo
//     DEPTH. Simultaneous push and pop when 0<count<DEPTH: count is unchanged. Pop when
//     empty is ignored.
//   Latency: a byte pushed in cycle N is visible at out_data/out_valid from cycle N+1.
//     No same-cycle bypass when empty.
//   out_data when empty: holds the last head value; consumers must qualify it with
//     out_valid.
// TESTING
//   1 Reset, then push "  begin" with out_ready=1 -> out stream "begin", drop_cnt=2.
//   2 Push 'a',0x09,0x0A,0x20,'b' -> out "a b"; drop_cnt=2; a 0x20 is emitted once.
//   3 Push 0x01,'x',0x7F,0x1B -> out "x"; drop_cnt=3; a SPACE after 0x1B is still
//     emitted (prev_space=0).
//   4 out_ready=0, push 9 CHARs -> in_ready=0 after 8th; 9th held; raise out_ready ->
//     all 9 delivered in order, count wraps cleanly.
//   5 Fill 4, then push+pop every cycle for 20 cycles -> count stays 4, order preserved.
//   6 Assert reset (0) mid-stream with 5 buffered -> out_valid=0 immediately; after
//     release, "end" -> "end".

Source files
------------

// File: rtl/text_normalizer.sv
// text_normalizer: cleans a raw ASCII byte stream (whitespace collapse, control
// character removal) and buffers the cleaned characters in a small FWFT FIFO.
//
// Handshake (both sides): a beat transfers on a rising clk edge where
// valid && ready. in_ready is !full, taken from the registered count only, so a
// pop in the same cycle never frees room for a push. out_valid is !empty and
// out_data is the FIFO head; out_data is meaningful only while out_valid is high.
module text_normalizer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] DROP_MAX = '1;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              prev_space_q, prev_space_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [7:0]        head_q, head_d;

  logic       is_space, is_ctrl, keep;
  logic [7:0] push_data;
  logic       accept, push, pop;

  // Classify the incoming byte and decide whether it survives collapsing.
  always_comb begin
    is_space  = (in_data == 8'h20) || (in_data == 8'h09) ||
                (in_data == 8'h0A) || (in_data == 8'h0D);
    is_ctrl   = !is_space && ((in_data < 8'h20) || (in_data >= 8'h7F));
    keep      = is_space ? !prev_space_q : !is_ctrl;
    push_data = is_space ? 8'h20 : in_data;
  end

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && keep;
  assign pop       = out_valid && out_ready;
  assign out_data  = head_q;
  assign drop_cnt  = drop_cnt_q;

  // Next-state for pointers, occupancy, whitespace memory, drop counter and head.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    prev_space_d = prev_space_q;
    drop_cnt_d   = drop_cnt_q;
    head_d       = head_q;

    if (accept) begin
      if (is_space && keep) begin
        prev_space_d = 1'b1;
      end else if (!is_space && !is_ctrl) begin
        prev_space_d = 1'b0;
      end
      if (!keep && (drop_cnt_q != DROP_MAX)) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // The head register tracks the entry that will sit at rd_ptr next cycle.
    // When the FIFO is (or becomes) empty except for this cycle's push, the
    // pushed byte is not yet in memory, so take it straight from push_data.
    // When the FIFO drains, head_q simply holds its last value.
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        head_d = push_data;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  // Control state registers; reset discards any buffered data immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      prev_space_q <= 1'b1;
      drop_cnt_q   <= '0;
      head_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      prev_space_q <= prev_space_d;
      drop_cnt_q   <= drop_cnt_d;
      head_q       <= head_d;
    end
  end

  // FIFO storage; contents are only meaningful under count_q, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: tb/tb_text_normalizer.sv
// tb_text_normalizer: directed scenarios plus randomized traffic against a
// queue-based reference model of the normalizer.
module tb_text_normalizer;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  // Narrow drop counter so saturation is reachable in a short run.
  localparam int CNT_W  = 5;
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_ready;
  logic [CNT_W-1:0] drop_cnt;

  text_normalizer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .drop_cnt (drop_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model / scoreboard ----------------
  logic [7:0] exp_q[$];     // bytes the FIFO should currently hold, head first
  logic [7:0] out_log[$];   // bytes the consumer has taken
  logic [7:0] last_head;
  bit         m_prev_space;
  int         m_drop;
  int         vec_cnt;
  int         fail_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    out_log.delete();
    last_head    = 8'h00;
    m_prev_space = 1'b1;
    m_drop       = 0;
  endfunction

  // Apply the normalization rules to one accepted byte.
  function automatic void model_accept(input logic [7:0] b);
    bit white = (b == 8'd32) || (b == 8'd9) || (b == 8'd10) || (b == 8'd13);
    bit ctrl  = !white && (b < 8'd32 || b > 8'd126);
    bit kept  = 1'b0;
    if (white) begin
      if (!m_prev_space) begin
        exp_q.push_back(8'h20);
        kept = 1'b1;
      end
      m_prev_space = 1'b1;
    end else if (!ctrl) begin
      exp_q.push_back(b);
      kept = 1'b1;
      m_prev_space = 1'b0;
    end
    if (!kept && m_drop < DROP_MAX) m_drop++;
  endfunction

  // Called at a negedge: check outputs, predict the coming posedge, advance.
  task automatic tick(output bit acc);
    bit have = (exp_q.size() > 0);
    if (have) last_head = exp_q[0];
    chk("in_ready",  in_ready,  exp_q.size() < DEPTH);
    chk("out_valid", out_valid, have);
    chk("out_data",  out_data,  last_head);
    chk("drop_cnt",  drop_cnt,  m_drop);
    acc = in_valid && (exp_q.size() < DEPTH);
    if (have && out_ready) begin
      out_log.push_back(exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (acc) model_accept(in_data);
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] b);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50 && !acc; i++) tick(acc);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick(acc);
    if (exp_q.size() > 0) chk("drain_timeout", 32'd0, 32'd1);
    tick(acc);
  endtask

  task automatic expect_bytes(input string tag, input logic [7:0] want[$]);
    chk({tag, "_len"}, out_log.size(), want.size());
    for (int i = 0; i < want.size(); i++) begin
      chk(tag, (i < out_log.size()) ? out_log[i] : 8'h00, want[i]);
    end
    out_log.delete();
  endtask

  task automatic expect_str(input string tag, input string s);
    logic [7:0] w[$];
    for (int i = 0; i < s.len(); i++) w.push_back(s[i]);
    expect_bytes(tag, w);
  endtask

  function automatic logic [7:0] rand_byte();
    int sel = $urandom_range(0, 9);
    logic [7:0] ws[4];
    ws[0] = 8'h20; ws[1] = 8'h09; ws[2] = 8'h0A; ws[3] = 8'h0D;
    if (sel <= 2)      return ws[$urandom_range(0, 3)];
    else if (sel == 3) return 8'($urandom_range(0, 31));
    else if (sel == 4) return 8'($urandom_range(127, 255));
    else               return 8'($urandom_range(33, 126));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bit acc;
    logic [7:0] want[$];
    vec_cnt   = 0;
    fail_cnt  = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_out_data",  out_data,  8'h00);
    chk("rst_drop_cnt",  drop_cnt,  0);
    reset = 1'b1;

    // Leading whitespace is dropped.
    out_ready = 1'b1;
    send_str("  begin");
    drain();
    expect_str("t1_stream", "begin");
    chk("t1_drop", drop_cnt, 2);

    // Whitespace run collapses to a single space.
    send(8'h61); send(8'h09); send(8'h0A); send(8'h20); send(8'h62);
    drain();
    expect_str("t2_stream", "a b");
    chk("t2_drop", drop_cnt, 4);

    // Control characters dropped without touching the whitespace state.
    send(8'h01); send(8'h78); send(8'h7F); send(8'h1B); send(8'h20);
    drain();
    expect_str("t3_stream", "x ");
    chk("t3_drop", drop_cnt, 7);

    // Fill to full with the consumer stalled; ninth byte waits.
    out_ready = 1'b0;
    send_str("ABCDEFGH");
    chk("t4_full_in_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    in_data  = "I";
    repeat (3) tick(acc);
    chk("t4_full_still", in_ready, 1'b0);
    out_ready = 1'b1;
    send("I");
    drain();
    expect_str("t4_stream", "ABCDEFGHI");

    // Four buffered, then push and pop together for 20 cycles.
    out_ready = 1'b0;
    send_str("pqrs");
    want.delete();
    want.push_back("p"); want.push_back("q"); want.push_back("r"); want.push_back("s");
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'("a" + (i % 26));
      want.push_back(in_data);
      tick(acc);
      chk("t5_accept", in_ready, 1'b1);
      chk("t5_nonempty", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    drain();
    expect_bytes("t5_stream", want);

    // Reset mid-stream with five buffered.
    out_ready = 1'b0;
    send_str("vwxyz");
    #3 reset = 1'b0;
    #1;
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_in_ready",  in_ready,  1'b1);
    chk("t6_out_data",  out_data,  8'h00);
    chk("t6_drop_cnt",  drop_cnt,  0);
    model_reset();
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    send_str("end");
    drain();
    expect_str("t6_stream", "end");

    // Drop counter saturates.
    for (int i = 0; i < DROP_MAX + 9; i++) send(8'h1B);
    drain();
    chk("sat_drop", drop_cnt, DROP_MAX);
    out_log.delete();

    // Randomized traffic checked cycle by cycle against the model.
    model_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rand_byte();
      out_ready = ($urandom_range(0, 2) != 0);
      tick(acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule
